// File: rtl/data_bus_interface_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_interface_pkg
//
// Shared definitions for the Wishbone B4 classic data-bus master:
//   - state_e         : master FSM states (IDLE, BUSY, HOLD)
//   - ZERO_WORD       : 32-bit zero returned on cpu_rdata when no load data
//   - DEFAULT_TIMEOUT : default BUSY-cycle limit before a timeout abort
//   - CNT_W           : width of the timeout counter (covers TIMEOUT 1..255)
// -----------------------------------------------------------------------------
package data_bus_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no access outstanding; accept a new MEM request
    ST_BUSY = 2'd1,  // cyc/stb asserted, waiting for the slave ack
    ST_HOLD = 2'd2   // access done, pipeline frozen: replay the result
  } state_e;

  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int unsigned CNT_W           = 8;

  // Last counter value before abort. The counter is cleared on entry to BUSY,
  // so BUSY cycle n sees count n-1 and the abort lands in BUSY cycle TIMEOUT.
  function automatic logic [CNT_W-1:0] last_count(input int unsigned timeout);
    return CNT_W'(timeout - 1);
  endfunction

endpackage : data_bus_interface_pkg

// File: rtl/data_bus_interface.sv
// -----------------------------------------------------------------------------
// data_bus_interface
//
// Wishbone B4 classic master for the MEM stage. A single-cycle data-memory
// request becomes a multi-cycle bus transaction. The block holds the pipeline
// with stall_req until the slave acks. It returns load data on cpu_rdata in
// the ack cycle. While another stage freezes the pipeline, it replays that
// data from a buffer so the access is not issued a second time. Pipeline
// flush or a bus timeout aborts the transaction.
//
// Parameters
//   TIMEOUT    max BUSY cycles without ack before abort (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   cpu_ce     in   MEM-stage memory request valid
//   cpu_we     in   1 = store, 0 = load
//   cpu_addr   in   [31:0] byte address (passed unmodified)
//   cpu_sel    in   [3:0]  byte lanes, big-endian (4'b1000 = bits 31:24)
//   cpu_wdata  in   [31:0] lane-replicated store data
//   cpu_rdata  out  [31:0] load data to the MEM stage
//   stall_in   in   pipeline frozen by another stage
//   flush      in   exception flush, kills any in-progress request
//   stall_req  out  stall request to pipeline control
//   bus_err    out  one-cycle pulse on timeout abort
//   wb_adr_o   out  [31:0] registered Wishbone address
//   wb_dat_o   out  [31:0] registered Wishbone write data
//   wb_sel_o   out  [3:0]  registered Wishbone byte select
//   wb_we_o    out  registered Wishbone write enable
//   wb_stb_o   out  registered Wishbone strobe (always equal to wb_cyc_o)
//   wb_cyc_o   out  registered Wishbone cycle
//   wb_dat_i   in   [31:0] Wishbone read data
//   wb_ack_i   in   Wishbone acknowledge
// -----------------------------------------------------------------------------
module data_bus_interface
  import data_bus_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_ce,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,

  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_req,
  output logic        bus_err,

  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = last_count(TIMEOUT);

  state_e           state_q,  state_d;
  logic [31:0]      adr_q,    adr_d;
  logic [31:0]      dat_q,    dat_d;
  logic [3:0]       sel_q,    sel_d;
  logic             we_q,     we_d;
  logic             cyc_q,    cyc_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    rd_buf_d  = rd_buf_q;
    cnt_d     = cnt_q;
    stall_req = 1'b0;
    cpu_rdata = ZERO_WORD;
    bus_err   = 1'b0;

    if (rst) begin
      // Register reset happens in the sequential block. Keeping the
      // combinational outputs quiet here means nothing leaks out while
      // reset is held.
    end else if (flush) begin
      // Kill whatever is in flight. A late ack from the slave is then seen
      // in IDLE, where it has no effect.
      cyc_d   = 1'b0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_ce) begin
            stall_req = 1'b1;
            adr_d     = cpu_addr;
            dat_d     = cpu_wdata;
            sel_d     = cpu_sel;
            we_d      = cpu_we;
            cyc_d     = 1'b1;
            cnt_d     = '0;
            state_d   = ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (wb_ack_i) begin
            // Load data goes straight to the MEM stage in the ack cycle and is
            // also buffered in case the pipeline stays frozen.
            cpu_rdata = cpu_we ? ZERO_WORD : wb_dat_i;
            rd_buf_d  = cpu_we ? ZERO_WORD : wb_dat_i;
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            sel_d     = 4'b0000;
            state_d   = stall_in ? ST_HOLD : ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            // Timeout: release the pipeline with zero data and flag the error.
            bus_err   = 1'b1;
            cyc_d     = 1'b0;
            rd_buf_d  = ZERO_WORD;
            state_d   = stall_in ? ST_HOLD : ST_IDLE;
          end else begin
            stall_req = 1'b1;
            cnt_d     = cnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          // The MEM instruction is still present with cpu_ce high. Staying
          // here stops it from starting a second bus access.
          cpu_rdata = rd_buf_q;
          if (!stall_in) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge and their order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      adr_q    <= ZERO_WORD;
      dat_q    <= ZERO_WORD;
      sel_q    <= 4'b0000;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= ZERO_WORD;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
    end
  end

  // All Wishbone outputs come directly from registers. stb mirrors cyc
  // because classic single transfers never de-assert stb inside a cycle.
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule : data_bus_interface

// File: tb/tb_data_bus_interface.sv
// -----------------------------------------------------------------------------
// tb_data_bus_interface
//
// Directed bench for data_bus_interface with TIMEOUT = 4. The stimulus is a
// linear sequence of steps. Inputs change 1 ns after each rising edge, and
// outputs are sampled 1 ns after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_data_bus_interface;

  logic        clk;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall_in;
  logic        flush;
  logic        stall_req;
  logic        bus_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int vectors;
  int miscompares;
  int stall_cycles;

  data_bus_interface #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_sel   (cpu_sel),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall_in  (stall_in),
    .flush     (flush),
    .stall_req (stall_req),
    .bus_err   (bus_err),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    check({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    stall_cycles = 0;
    rst       = 1'b1;
    cpu_ce    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_sel   = 4'h0;
    cpu_wdata = 32'h0;
    stall_in  = 1'b0;
    flush     = 1'b0;
    wb_dat_i  = 32'h0;
    wb_ack_i  = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    settle();
    check_bus_idle("rst");
    check("rst_adr",   wb_adr_o, 32'h0);
    check("rst_sel",   {28'd0, wb_sel_o}, 32'h0);
    check("rst_we",    {31'd0, wb_we_o}, 32'h0);
    check("rst_stall", {31'd0, stall_req}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_err",   {31'd0, bus_err}, 32'h0);
    rst = 1'b0;
    tick();

    // ---- load acked in the first BUSY cycle ----
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_sel = 4'hF;
    settle();
    check("ld1_idle_stall", {31'd0, stall_req}, 32'd1);
    check("ld1_idle_cyc",   {31'd0, wb_cyc_o}, 32'd0);
    tick();                                   // BUSY cycle 1
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    settle();
    check("ld1_busy_cyc",   {31'd0, wb_cyc_o}, 32'd1);
    check("ld1_busy_stb",   {31'd0, wb_stb_o}, 32'd1);
    check("ld1_busy_adr",   wb_adr_o, 32'h0000_0040);
    check("ld1_busy_sel",   {28'd0, wb_sel_o}, 32'hF);
    check("ld1_ack_stall",  {31'd0, stall_req}, 32'd0);
    check("ld1_ack_rdata",  cpu_rdata, 32'h1234_5678);
    tick();                                   // back in IDLE
    cpu_ce = 1'b0; wb_ack_i = 1'b0;
    settle();
    check_bus_idle("ld1_after");
    check("ld1_after_sel",  {28'd0, wb_sel_o}, 32'h0);
    check("ld1_after_stall", {31'd0, stall_req}, 32'd0);

    // ---- store, ack in BUSY cycle 3 ----
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100;
    cpu_sel = 4'b0011; cpu_wdata = 32'hABCD_ABCD;
    settle();
    if (stall_req) stall_cycles++;
    for (int c = 1; c <= 3; c++) begin
      tick();                                 // BUSY cycle c
      if (c == 3) wb_ack_i = 1'b1;
      settle();
      if (stall_req) stall_cycles++;
      check("st_adr",   wb_adr_o, 32'h0000_0100);
      check("st_dat",   wb_dat_o, 32'hABCD_ABCD);
      check("st_sel",   {28'd0, wb_sel_o}, 32'h3);
      check("st_we",    {31'd0, wb_we_o}, 32'd1);
      check("st_cyc",   {31'd0, wb_cyc_o}, 32'd1);
      check("st_rdata", cpu_rdata, 32'h0);
    end
    check("st_stall_cycles", stall_cycles, 32'd3);
    tick();
    cpu_ce = 1'b0; wb_ack_i = 1'b0;
    settle();
    check_bus_idle("st_after");
    check("st_after_we", {31'd0, wb_we_o}, 32'd0);

    // ---- load acked while frozen, then HOLD ----
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200; cpu_sel = 4'hF;
    tick();                                   // BUSY cycle 1
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall_in = 1'b1;
    settle();
    check("hold_ack_rdata", cpu_rdata, 32'hCAFE_F00D);
    tick();                                   // HOLD
    wb_ack_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
    for (int h = 0; h < 4; h++) begin
      wb_ack_i = (h == 2);                    // stray ack in HOLD is ignored
      settle();
      check("hold_rdata", cpu_rdata, 32'hCAFE_F00D);
      check("hold_stall", {31'd0, stall_req}, 32'd0);
      check("hold_cyc",   {31'd0, wb_cyc_o}, 32'd0);
      tick();
    end
    wb_ack_i = 1'b0; stall_in = 1'b0; cpu_ce = 1'b0;
    settle();
    check("hold_release_rdata", cpu_rdata, 32'hCAFE_F00D);
    tick();                                   // IDLE
    settle();
    check("hold_idle_rdata", cpu_rdata, 32'h0);
    check_bus_idle("hold_idle");

    // ---- flush in BUSY cycle 2, late ack ignored ----
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300;
    tick();                                   // BUSY 1
    tick();                                   // BUSY 2
    flush = 1'b1;
    settle();
    check("fl_stall", {31'd0, stall_req}, 32'd0);
    check("fl_rdata", cpu_rdata, 32'h0);
    check("fl_cyc_before_edge", {31'd0, wb_cyc_o}, 32'd1);
    tick();                                   // IDLE
    flush = 1'b0; cpu_ce = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0055;
    settle();
    check_bus_idle("fl_after");
    check("fl_late_stall", {31'd0, stall_req}, 32'd0);
    check("fl_late_rdata", cpu_rdata, 32'h0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    check_bus_idle("fl_after2");

    // ---- timeout after 4 BUSY cycles ----
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0400;
    for (int b = 1; b <= 3; b++) begin
      tick();                                 // BUSY cycle b
      settle();
      check("to_wait_stall", {31'd0, stall_req}, 32'd1);
      check("to_wait_err",   {31'd0, bus_err}, 32'd0);
    end
    tick();                                   // BUSY cycle 4
    settle();
    check("to_err",   {31'd0, bus_err}, 32'd1);
    check("to_stall", {31'd0, stall_req}, 32'd0);
    check("to_rdata", cpu_rdata, 32'h0);
    check("to_cyc",   {31'd0, wb_cyc_o}, 32'd1);
    tick();                                   // IDLE
    cpu_ce = 1'b0;
    settle();
    check("to_after_err", {31'd0, bus_err}, 32'd0);
    check_bus_idle("to_after");

    // ---- back-to-back requests ----
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500;
    tick();                                   // BUSY 1
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0011;
    tick();                                   // IDLE, next request ready
    wb_ack_i = 1'b0; cpu_addr = 32'h0000_0504;
    settle();
    check("b2b_gap_cyc",   {31'd0, wb_cyc_o}, 32'd0);
    check("b2b_gap_stall", {31'd0, stall_req}, 32'd1);
    tick();                                   // BUSY 1 of second access
    settle();
    check("b2b_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("b2b_adr", wb_adr_o, 32'h0000_0504);

    // ---- reset asserted mid-BUSY ----
    rst = 1'b1; cpu_ce = 1'b0;
    tick();
    settle();
    check_bus_idle("rst_mid");
    check("rst_mid_adr",   wb_adr_o, 32'h0);
    check("rst_mid_stall", {31'd0, stall_req}, 32'd0);
    check("rst_mid_rdata", cpu_rdata, 32'h0);
    check("rst_mid_err",   {31'd0, bus_err}, 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_bus_interface
